fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the PC/address width (>= 8).
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC loaded on reset (word-aligned).
REQ-003 Parameter IQ_DEPTH, default 2, SHALL set the instruction-queue depth (power of 2, >= 2).
REQ-004 clk_i  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_i  input  1  reset; asynchronous, active-low.
REQ-006 imem_req_o  output  1  fetch request to instruction memory.
REQ-007 imem_addr_o  output  XLEN  fetch address, equal to the internal fetch PC.
REQ-008 imem_gnt_i  input  1  memory accepts the request in this cycle.
REQ-009 imem_rvalid_i  input  1  read data valid, at least 1 cycle after grant.
REQ-010 imem_rdata_i  input  32  instruction word.
REQ-011 redirect_i  input  1  branch/jump taken; flush and restart fetch.
REQ-012 redirect_pc_i  input  XLEN  new fetch PC, word-aligned.
REQ-013 instr_valid_o  output  1  queue head holds a valid instruction.
REQ-014 instr_o  output  32  queue-head instruction.
REQ-015 instr_pc_o  output  XLEN  PC of the queue-head instruction.
REQ-016 instr_ready_i  input  1  consumer pops the head when high together with instr_valid_o.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, HOLD and DROP; at most one memory request SHALL be outstanding.
REQ-018 IDLE: go to REQ on the next edge unconditionally.
REQ-019 REQ: imem_req_o=1, imem_addr_o=fetch PC; on imem_gnt_i go to WAIT.
REQ-020 WAIT: imem_req_o=0; on imem_rvalid_i push {fetch PC, imem_rdata_i}, fetch PC += 4 modulo 2^XLEN, go to REQ if the post-push/pop count < IQ_DEPTH, otherwise HOLD.
REQ-021 HOLD: imem_req_o=0; go to REQ when the queue count (after this cycle's pop) < IQ_DEPTH.
REQ-022 REQ SHALL be entered only with a free slot, so a push SHALL never find the queue full.
REQ-023 Queue: FIFO with wrap-around pointers; a push and a pop in the same cycle leave the count unchanged.
REQ-024 The queue SHALL provide first-word fall-through: instr_valid_o = count != 0, and instr_o/instr_pc_o SHALL be the head entry.
REQ-025 A push into an empty queue SHALL make instr_valid_o high in the following cycle.
REQ-026 Redirect, any state: queue count SHALL be 0 and fetch PC SHALL equal redirect_pc_i next cycle; any same-cycle pop or push SHALL be discarded.
REQ-027 Redirect in REQ without grant, or in HOLD or IDLE: go to REQ (imem_addr_o may change while imem_req_o is high, only in this case).
REQ-028 Redirect in REQ with imem_gnt_i, or in WAIT without imem_rvalid_i: go to DROP.
REQ-029 Redirect in WAIT with imem_rvalid_i: discard the data and go to REQ.
REQ-030 DROP: imem_req_o=0; discard the next imem_rvalid_i response, then go to REQ.
REQ-031 Redirect in DROP with imem_rvalid_i: discard the data and go to REQ.
REQ-032 Redirect in DROP without imem_rvalid_i: stay in DROP.
REQ-033 Otherwise, fetch PC SHALL hold while imem_req_o is high.
REQ-034 imem_rvalid_i outside WAIT/DROP SHALL be ignored.

Reset
REQ-035 While rst_i=0: state=IDLE, fetch PC=RESET_PC, queue pointers/count=0, imem_req_o=0, instr_valid_o=0, outputs stable regardless of clk_i.
REQ-036 Reset asserted mid-request SHALL abandon the request; no response SHALL be pushed after reset release unless newly requested.
REQ-037 Queue storage needs no reset; instr_o/instr_pc_o are don't-care while instr_valid_o=0.

Verification
REQ-038 Reset release, gnt and rvalid one cycle after req, ready=1 -> imem_req_o high in cycle 1 at addr 0x0; instr_valid_o high in cycle 3 with instr_pc_o=0x0; steady throughput one instruction per 2 cycles.
REQ-039 ready=0, zero-latency memory, IQ_DEPTH=2 -> exactly 2 pushes (PC 0x0, 0x4), state HOLD, imem_req_o=0; ready=1 for one cycle -> head becomes PC 0x4 and exactly one new request at 0x8.
REQ-040 Redirect to 0x100 in the same cycle as a grant for 0x8 -> queue empty next cycle, the 0x8 response dropped, next request at 0x100, first valid instr_pc_o=0x100.
REQ-041 Redirect to 0x40 coincident with rvalid and a pop -> the data is not pushed, count=0, no instruction is lost beyond the flush, next imem_addr_o=0x40.
REQ-042 rst_i low asynchronously in WAIT with 1 queued entry -> instr_valid_o and imem_req_o fall immediately; a late rvalid after release is ignored; the first request after release is at RESET_PC.
REQ-043 RESET_PC=0xFFFFFFFC, XLEN=32 -> second fetch address wraps to 0x00000000.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: the instruction-memory request/response channel and
// the instruction-queue head/pop channel, seen from the fetch unit (master).
`default_nettype none

interface fetch_unit_if #(
   parameter int XLEN = 32
);
   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [31:0]     imem_rdata_i;
   logic            instr_valid_o;
   logic [31:0]     instr_o;
   logic [XLEN-1:0] instr_pc_o;
   logic            instr_ready_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i,
      output instr_valid_o,
      output instr_o,
      output instr_pc_o,
      input  instr_ready_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i,
      input  instr_valid_o,
      input  instr_o,
      input  instr_pc_o,
      output instr_ready_i
   );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetch FSM feeding a
// first-word-fall-through instruction queue, with redirect flush.
`default_nettype none

module fetch_unit #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              IQ_DEPTH = 2
) (
   input  wire             clk_i,
   input  wire             rst_i,
   fetch_unit_if.master    bus,
   input  wire             redirect_i,
   input  wire [XLEN-1:0]  redirect_pc_i
);

   localparam int PTR_W = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IQ_DEPTH);
   localparam logic [XLEN-1:0]  PC_INC  = XLEN'(4);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_DROP = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [XLEN-1:0]    pc_q, pc_d;
   logic [PTR_W-1:0]   wptr_q, wptr_d;
   logic [PTR_W-1:0]   rptr_q, rptr_d;
   logic [CNT_W-1:0]   count_q, count_d;

   logic [31:0]        iq_instr_q [IQ_DEPTH];
   logic [XLEN-1:0]    iq_pc_q    [IQ_DEPTH];

   logic               push;
   logic               pop;
   logic [CNT_W-1:0]   count_after_pop;
   logic [CNT_W-1:0]   count_after_push;

   always_comb begin
      state_d          = state_q;
      pc_d             = pc_q;
      push             = 1'b0;
      pop              = (count_q != '0) && bus.instr_ready_i;
      count_after_pop  = count_q - {{(CNT_W-1){1'b0}}, pop};
      count_after_push = count_after_pop + CNT_W'(1);

      case (state_q)
         S_IDLE: state_d = S_REQ;

         S_REQ: begin
            if (redirect_i) begin
               state_d = bus.imem_gnt_i ? S_DROP : S_REQ;
            end else if (bus.imem_gnt_i) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (bus.imem_rvalid_i) begin
               state_d = S_REQ;
               if (!redirect_i) begin
                  push = 1'b1;
                  pc_d = pc_q + PC_INC;
                  if (count_after_push >= DEPTH_C) state_d = S_HOLD;
               end
            end else if (redirect_i) begin
               state_d = S_DROP;
            end
         end

         S_HOLD: begin
            if (redirect_i || (count_after_pop < DEPTH_C)) state_d = S_REQ;
         end

         // The response to an abandoned grant is still owed; swallow it.
         S_DROP: begin
            if (bus.imem_rvalid_i) state_d = S_REQ;
         end

         default: state_d = S_IDLE;
      endcase

      wptr_d  = wptr_q + PTR_W'(push);
      rptr_d  = rptr_q + PTR_W'(pop);
      count_d = count_after_pop + CNT_W'(push);

      if (redirect_i) begin
         pc_d    = redirect_pc_i;
         wptr_d  = '0;
         rptr_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Queue storage is never read while empty, so it carries no reset.
   always_ff @(posedge clk_i) begin
      if (push) begin
         iq_instr_q[wptr_q] <= bus.imem_rdata_i;
         iq_pc_q[wptr_q]    <= pc_q;
      end
   end

   assign bus.imem_req_o    = (state_q == S_REQ);
   assign bus.imem_addr_o   = pc_q;
   assign bus.instr_valid_o = (count_q != '0);
   assign bus.instr_o       = iq_instr_q[rptr_q];
   assign bus.instr_pc_o    = iq_pc_q[rptr_q];

   a_no_push_when_full : assert property (
      @(posedge clk_i) disable iff (!rst_i) push |-> (count_q != DEPTH_C));

   a_count_bounded : assert property (
      @(posedge clk_i) disable iff (!rst_i) count_q <= DEPTH_C);

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, latency, back-pressure,
// redirect flush cases, asynchronous reset mid-fetch and PC wrap-around.
`default_nettype none

module tb_fetch_unit;

   localparam logic [31:0] DATA_OFS = 32'h1300_0000;

   logic        clk;
   logic        rst_n;
   logic        gnt_en;
   logic        rvalid_en;
   logic        redirect;
   logic [31:0] redirect_pc;

   int n_checks = 0;
   int n_pass   = 0;

   fetch_unit_if #(.XLEN(32)) bus  ();
   fetch_unit_if #(.XLEN(32)) bus2 ();

   fetch_unit #(.XLEN(32), .RESET_PC(32'h0), .IQ_DEPTH(2)) dut (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .bus           (bus.master),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc)
   );

   fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .IQ_DEPTH(2)) dut_wrap (
      .clk_i         (clk),
      .rst_i         (rst_n),
      .bus           (bus2.master),
      .redirect_i    (1'b0),
      .redirect_pc_i (32'h0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: grant when enabled, respond no earlier than the next cycle.
   logic        pend      = 1'b0;
   logic [31:0] pend_addr = '0;
   int          n_gnt     = 0;

   assign bus.imem_gnt_i    = bus.imem_req_o & gnt_en;
   assign bus.imem_rvalid_i = pend & rvalid_en;
   assign bus.imem_rdata_i  = pend_addr + DATA_OFS;

   always @(posedge clk) begin
      if (bus.imem_req_o && bus.imem_gnt_i) begin
         pend      <= 1'b1;
         pend_addr <= bus.imem_addr_o;
         n_gnt     <= n_gnt + 1;
      end else if (bus.imem_rvalid_i) begin
         pend <= 1'b0;
      end
   end

   logic        pend2      = 1'b0;
   logic [31:0] pend2_addr = '0;
   logic [31:0] g2_a0      = '0;
   logic [31:0] g2_a1      = '0;
   int          g2_cnt     = 0;

   assign bus2.imem_gnt_i    = bus2.imem_req_o;
   assign bus2.imem_rvalid_i = pend2;
   assign bus2.imem_rdata_i  = pend2_addr + DATA_OFS;
   assign bus2.instr_ready_i = 1'b1;

   always @(posedge clk) begin
      if (bus2.imem_req_o && bus2.imem_gnt_i) begin
         pend2      <= 1'b1;
         pend2_addr <= bus2.imem_addr_o;
      end else if (bus2.imem_rvalid_i) begin
         pend2 <= 1'b0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         g2_cnt <= 0;
      end else if (bus2.imem_req_o && bus2.imem_gnt_i) begin
         if (g2_cnt == 0) g2_a0 <= bus2.imem_addr_o;
         if (g2_cnt == 1) g2_a1 <= bus2.imem_addr_o;
         g2_cnt <= g2_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Advance negedge by negedge until the queue head is valid, bounded.
   task automatic wait_valid(input string tag);
      bit found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (bus.instr_valid_o) found = 1'b1;
      end
      check(tag, 64'(found), 64'd1);
   endtask

   initial begin
      int  base;
      int  pops;
      bit  found;
      logic [31:0] exp_pc;

      rst_n               = 1'b0;
      gnt_en              = 1'b1;
      rvalid_en           = 1'b1;
      redirect            = 1'b0;
      redirect_pc         = '0;
      bus.instr_ready_i   = 1'b1;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_req",       64'(bus.imem_req_o),    64'd0);
      check("rst_valid",     64'(bus.instr_valid_o), 64'd0);
      check("rst_addr",      64'(bus.imem_addr_o),   64'h0);
      check("rst_addr_wrap", 64'(bus2.imem_addr_o),  64'hFFFF_FFFC);

      // First-fetch latency and steady throughput
      rst_n = 1'b1;
      @(negedge clk);
      check("c1_req",   64'(bus.imem_req_o),    64'd1);
      check("c1_addr",  64'(bus.imem_addr_o),   64'h0);
      @(negedge clk);
      check("c2_req",   64'(bus.imem_req_o),    64'd0);
      check("c2_valid", 64'(bus.instr_valid_o), 64'd0);
      @(negedge clk);
      check("c3_valid", 64'(bus.instr_valid_o), 64'd1);
      check("c3_pc",    64'(bus.instr_pc_o),    64'h0);
      check("c3_instr", 64'(bus.instr_o),       64'h1300_0000);
      pops   = 0;
      exp_pc = 32'h0;
      for (int i = 0; i < 8; i++) begin
         if (bus.instr_valid_o) begin
            check("stream_pc", 64'(bus.instr_pc_o), 64'(exp_pc));
            exp_pc = exp_pc + 32'd4;
            pops++;
         end
         @(negedge clk);
      end
      check("throughput_pops_in_8", 64'(pops), 64'd4);

      // Back-pressure fills the queue, then a single pop frees one slot
      bus.instr_ready_i = 1'b0;
      do_reset();
      base = n_gnt;
      repeat (10) @(negedge clk);
      check("bp_grants",   64'(n_gnt - base),      64'd2);
      check("bp_hold_req", 64'(bus.imem_req_o),    64'd0);
      check("bp_head_pc",  64'(bus.instr_pc_o),    64'h0);
      bus.instr_ready_i = 1'b1;
      @(negedge clk);
      bus.instr_ready_i = 1'b0;
      check("bp_pop_head", 64'(bus.instr_pc_o),    64'h4);
      check("bp_pop_req",  64'(bus.imem_req_o),    64'd1);
      check("bp_pop_addr", 64'(bus.imem_addr_o),   64'h8);
      repeat (6) @(negedge clk);
      check("bp_one_more_grant", 64'(n_gnt - base),   64'd3);
      check("bp_hold_again",     64'(bus.imem_req_o), 64'd0);
      check("bp_head_kept",      64'(bus.instr_pc_o), 64'h4);

      // Redirect in the same cycle as the grant for 0x8
      bus.instr_ready_i = 1'b1;
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (bus.imem_req_o && bus.imem_addr_o == 32'h8) found = 1'b1;
      end
      check("rd1_req8_seen", 64'(found), 64'd1);
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      @(negedge clk);
      redirect = 1'b0;
      check("rd1_flush_valid", 64'(bus.instr_valid_o), 64'd0);
      check("rd1_drop_req",    64'(bus.imem_req_o),    64'd0);
      check("rd1_new_pc",      64'(bus.imem_addr_o),   64'h100);
      @(negedge clk);
      check("rd1_req_after_drop", 64'(bus.imem_req_o),  64'd1);
      check("rd1_addr",           64'(bus.imem_addr_o), 64'h100);
      wait_valid("rd1_valid_timeout");
      check("rd1_first_pc",    64'(bus.instr_pc_o), 64'h100);
      check("rd1_first_instr", 64'(bus.instr_o),    64'h1300_0100);

      // Redirect coincident with rvalid and a pop
      bus.instr_ready_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (!bus.imem_req_o && bus.imem_rvalid_i && bus.instr_valid_o) found = 1'b1;
      end
      check("rd2_wait_seen", 64'(found), 64'd1);
      bus.instr_ready_i = 1'b1;
      redirect          = 1'b1;
      redirect_pc       = 32'h40;
      @(negedge clk);
      redirect          = 1'b0;
      bus.instr_ready_i = 1'b0;
      check("rd2_flush_valid", 64'(bus.instr_valid_o), 64'd0);
      check("rd2_req",         64'(bus.imem_req_o),    64'd1);
      check("rd2_addr",        64'(bus.imem_addr_o),   64'h40);
      wait_valid("rd2_valid_timeout");
      check("rd2_first_pc",    64'(bus.instr_pc_o), 64'h40);
      check("rd2_first_instr", 64'(bus.instr_o),    64'h1300_0040);

      // Asynchronous reset while waiting with one queued entry
      rvalid_en = 1'b0;
      @(negedge clk);
      check("ar_pre_valid", 64'(bus.instr_valid_o), 64'd1);
      check("ar_pre_req",   64'(bus.imem_req_o),    64'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_valid_fall", 64'(bus.instr_valid_o), 64'd0);
      check("ar_req_low",    64'(bus.imem_req_o),    64'd0);
      check("ar_pc_reset",   64'(bus.imem_addr_o),   64'h0);
      @(negedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      rvalid_en = 1'b1;
      @(negedge clk);
      check("ar_late_rvalid_ignored", 64'(bus.instr_valid_o), 64'd0);
      check("ar_first_req",           64'(bus.imem_req_o),    64'd1);
      check("ar_first_addr",          64'(bus.imem_addr_o),   64'h0);
      wait_valid("ar_valid_timeout");
      check("ar_first_pc",    64'(bus.instr_pc_o), 64'h0);
      check("ar_first_instr", 64'(bus.instr_o),    64'h1300_0000);

      // PC wrap-around from RESET_PC = 0xFFFFFFFC
      repeat (4) @(negedge clk);
      check("wrap_grants", 64'(g2_cnt >= 2), 64'd1);
      check("wrap_addr0",  64'(g2_a0),       64'hFFFF_FFFC);
      check("wrap_addr1",  64'(g2_a1),       64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
